// File: rtl/div_issue_ctrl_pkg.sv
// Shared definitions for the divider issue controller: FSM state encodings,
// HI/LO result field positions and the default annul hold length.
package div_issue_ctrl_pkg;

    typedef enum logic [1:0] {
        DIV_CTRL_IDLE    = 2'd0,
        DIV_CTRL_BUSY    = 2'd1,
        DIV_CTRL_RELEASE = 2'd2,
        DIV_CTRL_ABORT   = 2'd3
    } div_ctrl_state_e;

    localparam int unsigned DIV_DATA_W           = 32;
    localparam int unsigned DIV_ABORT_CYCLES_DEF = 2;

    // Divider result layout: remainder in the upper half, quotient in the lower.
    localparam int unsigned DIV_HI_MSB = 63;
    localparam int unsigned DIV_HI_LSB = 32;
    localparam int unsigned DIV_LO_MSB = 31;
    localparam int unsigned DIV_LO_LSB = 0;

    function automatic logic [DIV_DATA_W-1:0] div_res_hi(input logic [2*DIV_DATA_W-1:0] res);
        return res[DIV_HI_MSB:DIV_HI_LSB];
    endfunction

    function automatic logic [DIV_DATA_W-1:0] div_res_lo(input logic [2*DIV_DATA_W-1:0] res);
        return res[DIV_LO_MSB:DIV_LO_LSB];
    endfunction

endpackage

// File: rtl/div_issue_ctrl.sv
// EX-stage controller in front of the iterative divider: latches operands, runs the
// start/annul handshake, stalls the pipeline and captures HI/LO. Optional DIV_STALL_CNT_EN.
module div_issue_ctrl
    import div_issue_ctrl_pkg::*;
#(
    parameter int unsigned ABORT_CYCLES = DIV_ABORT_CYCLES_DEF,
    parameter int unsigned DATA_W       = DIV_DATA_W
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  div_req_i,
    input  logic                  div_signed_i,
    input  logic [DATA_W-1:0]     op_a_i,
    input  logic [DATA_W-1:0]     op_b_i,
    input  logic                  flush_i,
    output logic                  div_start_o,
    output logic                  div_annul_o,
    output logic                  div_signed_o,
    output logic [DATA_W-1:0]     div_opa_o,
    output logic [DATA_W-1:0]     div_opb_o,
    input  logic [2*DATA_W-1:0]   div_result_i,
    input  logic                  div_ready_i,
    output logic                  stall_o,
    output logic                  hilo_we_o,
    output logic [DATA_W-1:0]     hi_o,
    output logic [DATA_W-1:0]     lo_o
`ifdef DIV_STALL_CNT_EN
   ,output logic [31:0]           stall_cnt_o
`endif
);

    localparam int unsigned CNT_W = (ABORT_CYCLES > 1) ? $clog2(ABORT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] ABORT_LOAD = CNT_W'(ABORT_CYCLES - 1);

    div_ctrl_state_e   state, state_next;
    logic [CNT_W-1:0]  abort_cnt;
    logic [DATA_W-1:0] opa_q, opb_q;
    logic              signed_q;
    logic              accept;
    logic              complete;
    logic              cancel;

    assign accept   = (state == DIV_CTRL_IDLE) && div_req_i && !flush_i;
    assign cancel   = (state == DIV_CTRL_BUSY) && flush_i;
    assign complete = (state == DIV_CTRL_BUSY) && div_ready_i && !flush_i;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= DIV_CTRL_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        unique case (state)
            DIV_CTRL_IDLE: begin
                if (accept) state_next = DIV_CTRL_BUSY;
            end
            DIV_CTRL_BUSY: begin
                if (flush_i)          state_next = DIV_CTRL_ABORT;
                else if (div_ready_i) state_next = DIV_CTRL_RELEASE;
            end
            DIV_CTRL_RELEASE: state_next = DIV_CTRL_IDLE;
            DIV_CTRL_ABORT: begin
                if (abort_cnt == '0) state_next = DIV_CTRL_IDLE;
            end
            default: state_next = DIV_CTRL_IDLE;
        endcase
    end

    // In ABORT/RELEASE a waiting request is held off until IDLE can accept it.
    always_comb begin
        div_start_o = 1'b0;
        div_annul_o = 1'b0;
        stall_o     = 1'b0;
        unique case (state)
            DIV_CTRL_IDLE: begin
                stall_o = div_req_i && !flush_i;
            end
            DIV_CTRL_BUSY: begin
                div_start_o = 1'b1;
                stall_o     = !div_ready_i;
            end
            DIV_CTRL_RELEASE: begin
                stall_o = div_req_i;
            end
            DIV_CTRL_ABORT: begin
                div_annul_o = 1'b1;
                stall_o     = div_req_i;
            end
            default: begin
                stall_o = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            abort_cnt <= '0;
        end else if (cancel) begin
            abort_cnt <= ABORT_LOAD;
        end else if ((state == DIV_CTRL_ABORT) && (abort_cnt != '0)) begin
            abort_cnt <= abort_cnt - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            opa_q    <= '0;
            opb_q    <= '0;
            signed_q <= 1'b0;
        end else if (accept) begin
            opa_q    <= op_a_i;
            opb_q    <= op_b_i;
            signed_q <= div_signed_i;
        end
    end

    assign div_opa_o    = opa_q;
    assign div_opb_o    = opb_q;
    assign div_signed_o = signed_q;

    // A flush in the same cycle as ready wins, so the strobe and capture are suppressed.
    always_ff @(posedge clk) begin
        if (rst) begin
            hilo_we_o <= 1'b0;
            hi_o      <= '0;
            lo_o      <= '0;
        end else begin
            hilo_we_o <= complete;
            if (complete) begin
                hi_o <= div_res_hi(div_result_i);
                lo_o <= div_res_lo(div_result_i);
            end
        end
    end

`ifdef DIV_STALL_CNT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_o <= '0;
        end else if (stall_o) begin
            stall_cnt_o <= stall_cnt_o + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_div_issue_ctrl.sv
// Directed bench for div_issue_ctrl with a behavioural divider model driving ready/result.
module tb_div_issue_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        div_req, div_signed_in, flush;
    logic [31:0] op_a, op_b;
    logic        div_start, div_annul, div_signed;
    logic [31:0] div_opa, div_opb;
    logic [63:0] div_result = '0;
    logic        div_ready  = 1'b0;
    logic        stall, hilo_we;
    logic [31:0] hi, lo;
`ifdef DIV_STALL_CNT_EN
    logic [31:0] stall_cnt;
`endif

    int checks = 0;
    int errors = 0;
    int strobes = 0;
    int stall_seen = 0;
    int lat = 4;
    int mcnt = 0;

    always #5 clk = ~clk;

    div_issue_ctrl #(.ABORT_CYCLES(2), .DATA_W(32)) dut (
        .clk(clk), .rst(rst),
        .div_req_i(div_req), .div_signed_i(div_signed_in),
        .op_a_i(op_a), .op_b_i(op_b), .flush_i(flush),
        .div_start_o(div_start), .div_annul_o(div_annul), .div_signed_o(div_signed),
        .div_opa_o(div_opa), .div_opb_o(div_opb),
        .div_result_i(div_result), .div_ready_i(div_ready),
        .stall_o(stall), .hilo_we_o(hilo_we), .hi_o(hi), .lo_o(lo)
`ifdef DIV_STALL_CNT_EN
       ,.stall_cnt_o(stall_cnt)
`endif
    );

    function automatic logic [63:0] model_div(input logic s, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] q, r;
        if (b == 32'd0) begin
            q = '0;
            r = '0;
        end else if (s) begin
            q = $signed(a) / $signed(b);
            r = $signed(a) % $signed(b);
        end else begin
            q = a / b;
            r = a % b;
        end
        return {r, q};
    endfunction

    // Divider stand-in: ready appears `lat` cycles after start is seen; drops when start drops.
    always @(posedge clk) begin
        if (rst || div_annul || !div_start) begin
            mcnt      <= 0;
            div_ready <= 1'b0;
        end else if (!div_ready) begin
            if (mcnt >= lat - 1) begin
                div_ready  <= 1'b1;
                div_result <= model_div(div_signed, div_opa, div_opb);
            end else begin
                mcnt <= mcnt + 1;
            end
        end
    end

    always @(posedge clk) begin
        if (hilo_we) strobes++;
        if (rst) stall_seen = 0;
        else if (stall) stall_seen++;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic start_div(input string name, input logic sgn, input logic [31:0] a, input logic [31:0] b);
        div_req       = 1'b1;
        div_signed_in = sgn;
        op_a          = a;
        op_b          = b;
        flush         = 1'b0;
        #1;
        check({name, " stall_accept"}, 64'(stall), 64'd1);
        @(negedge clk);
        cycle();
        op_a = ~a;
        op_b = b ^ 32'h5a5a_5a5a;
        #1;
        check({name, " opa_latched"}, 64'(div_opa), 64'(a));
        check({name, " opb_latched"}, 64'(div_opb), 64'(b));
        check({name, " signed_latched"}, 64'(div_signed), 64'(sgn));
    endtask

    task automatic finish_div(input string name, input logic [31:0] exp_hi, input logic [31:0] exp_lo,
                              input logic nreq, input logic nsgn, input logic [31:0] na, input logic [31:0] nb);
        bit done = 0;
        @(negedge clk);
        for (int i = 0; i < 200; i++) begin
            if (div_ready) begin
                done = 1;
                break;
            end
            check({name, " busy_stall_start"}, 64'({stall, div_start}), 64'b11);
            cycle();
        end
        if (!done) check({name, " ready_timeout"}, 64'd0, 64'd1);
        check({name, " stall_at_ready"}, 64'(stall), 64'd0);
        div_req       = nreq;
        div_signed_in = nsgn;
        op_a          = na;
        op_b          = nb;
        cycle();
        check({name, " hilo_we"}, 64'(hilo_we), 64'd1);
        check({name, " hi"}, 64'(hi), 64'(exp_hi));
        check({name, " lo"}, 64'(lo), 64'(exp_lo));
        check({name, " release_start_stall"}, 64'({div_start, stall}), 64'({1'b0, nreq}));
        cycle();
        check({name, " hilo_we_once"}, 64'(hilo_we), 64'd0);
    endtask

    typedef struct {
        logic        sgn;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
    } vec_t;

    vec_t vecs[6];

    initial begin
        vecs[0] = '{1'b0, 32'd100,        32'd7,          32'd2,          32'd14};
        vecs[1] = '{1'b1, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFF,  32'hFFFF_FFFD};
        vecs[2] = '{1'b0, 32'd5,          32'd0,          32'd0,          32'd0};
        vecs[3] = '{1'b0, 32'd9,          32'd3,          32'd0,          32'd3};
        vecs[4] = '{1'b1, 32'd20,         32'hFFFF_FFFD,  32'd2,          32'hFFFF_FFFA};
        vecs[5] = '{1'b0, 32'hFFFF_FFFF,  32'd10,         32'd5,          32'h1999_9999};

        rst = 1'b1; div_req = 1'b0; div_signed_in = 1'b0; flush = 1'b0;
        op_a = '0; op_b = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_ctrl", 64'({div_start, div_annul, div_signed, stall, hilo_we}), 64'd0);
        check("reset_ops", {div_opa, div_opb}, 64'd0);
        check("reset_hilo", {hi, lo}, 64'd0);
        rst = 1'b0;
        cycle();

        for (int i = 0; i < 6; i++) begin
            lat = 2 + i * 3;
            start_div($sformatf("vec%0d", i), vecs[i].sgn, vecs[i].a, vecs[i].b);
            finish_div($sformatf("vec%0d", i), vecs[i].hi, vecs[i].lo, 1'b0, 1'b0, 32'd0, 32'd0);
        end
        cycle();
        check("strobes_table", 64'(strobes), 64'd6);

        // Flush in IDLE: request ignored, no stall, state stays IDLE.
        div_req = 1'b1; flush = 1'b1; op_a = 32'd1; op_b = 32'd1;
        #1;
        check("idle_flush_stall", 64'(stall), 64'd0);
        cycle();
        check("idle_flush_nostart", 64'(div_start), 64'd0);
        div_req = 1'b0; flush = 1'b0;
        cycle();

        // Flush at BUSY cycle 10.
        lat = 20;
        start_div("flush", 1'b0, 32'd50, 32'd5);
        repeat (9) cycle();
        check("flush_prebusy", 64'({div_start, div_ready}), 64'b10);
        flush = 1'b1;
        cycle();
        flush = 1'b0; div_req = 1'b0;
        #1;
        check("abort1_ctrl", 64'({div_start, div_annul, stall, hilo_we}), 64'b0100);
        cycle();
        div_req = 1'b1;
        #1;
        check("abort2_ctrl", 64'({div_start, div_annul, stall, hilo_we}), 64'b0110);
        cycle();
        check("abort_done", 64'({div_start, div_annul, hilo_we}), 64'b000);
        lat = 3;
        start_div("after_flush", 1'b0, 32'd9, 32'd3);
        finish_div("after_flush", 32'd0, 32'd3, 1'b0, 1'b0, 32'd0, 32'd0);
        cycle();
        check("strobes_flush", 64'(strobes), 64'd7);

        // Back-to-back DIVU 8/2 then 9/4.
        start_div("b2b_a", 1'b0, 32'd8, 32'd2);
        finish_div("b2b_a", 32'd0, 32'd4, 1'b1, 1'b0, 32'd9, 32'd4);
        start_div("b2b_b", 1'b0, 32'd9, 32'd4);
        finish_div("b2b_b", 32'd1, 32'd2, 1'b0, 1'b0, 32'd0, 32'd0);
        cycle();
        check("strobes_b2b", 64'(strobes), 64'd9);

        // rst while BUSY.
        lat = 20;
        start_div("rst_mid", 1'b0, 32'd100, 32'd7);
        repeat (3) cycle();
        rst = 1'b1; div_req = 1'b0;
        cycle();
        check("rst_mid_ctrl", 64'({div_start, div_annul, div_signed, stall, hilo_we}), 64'd0);
        check("rst_mid_ops", {div_opa, div_opb}, 64'd0);
        check("rst_mid_hilo", {hi, lo}, 64'd0);
`ifdef DIV_STALL_CNT_EN
        check("rst_mid_stall_cnt", 64'(stall_cnt), 64'd0);
`endif
        rst = 1'b0;
        cycle();

        lat = 4;
        start_div("post_rst", 1'b1, 32'hFFFF_FFF9, 32'd2);
        finish_div("post_rst", 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, 1'b0, 32'd0, 32'd0);
        cycle();
`ifdef DIV_STALL_CNT_EN
        check("stall_cnt", 64'(stall_cnt), 64'(stall_seen));
`endif
        check("strobes_final", 64'(strobes), 64'd10);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

endmodule
